// File: rtl/banked_mem_if.sv
// Request/response bundle for banked_mem: the requester drives the request
// side, the memory answers with read data, stall, busy and error flags.
interface banked_mem_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, data_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, data_valid, stall, busy, err
    );
endinterface

// File: rtl/banked_mem.sv
// 32K x 16 memory split into four banks on addr[2:1]; each bank is blocked for
// BUSY_CYCLES after an accept, reads return through a fixed two-stage pipeline.
module banked_mem #(
    parameter int BUSY_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    banked_mem_if.slave   bus
);
    localparam logic [2:0] BUSY_LOAD = 3'(BUSY_CYCLES - 1);

    logic [15:0] mem [0:32767];
    logic [2:0]  busy_cnt [0:3];
    logic [3:0]  busy_flags;

    logic [1:0]  bank;
    logic [14:0] word;
    logic        req;
    logic        err_now;
    logic        stall_now;
    logic        accept;
    logic        accept_wr;
    logic        accept_rd;

    logic [15:0] rd_word;
    logic        rd_valid_s1;
    logic        rd_valid_s2;
    logic [15:0] rd_data_s2;

    always_comb begin
        busy_flags = '0;
        for (int b = 0; b < 4; b++) begin
            busy_flags[b] = (busy_cnt[b] != 3'd0);
        end
    end

    assign bank      = bus.addr[2:1];
    assign word      = bus.addr[15:1];
    assign req       = bus.rd | bus.wr;
    assign err_now   = (bus.rd & bus.wr) | (req & bus.addr[0]);
    // Stall looks only at the target bank, never at read vs write.
    assign stall_now = req & ~err_now & busy_flags[bank];
    assign accept    = (bus.rd ^ bus.wr) & ~err_now & ~stall_now & ~rst;
    assign accept_wr = accept & bus.wr;
    assign accept_rd = accept & bus.rd;

    // Array and its read register carry no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem[word] <= bus.data_in;
        end
        if (accept_rd) begin
            rd_word <= mem[word];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                busy_cnt[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (accept && (bank == 2'(b))) begin
                    busy_cnt[b] <= BUSY_LOAD;
                end else if (busy_cnt[b] != 3'd0) begin
                    busy_cnt[b] <= busy_cnt[b] - 3'd1;
                end
            end
        end
    end

    // Stage 1 is the array read register plus its valid; stage 2 drives the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_s1 <= 1'b0;
            rd_valid_s2 <= 1'b0;
            rd_data_s2  <= 16'h0000;
        end else begin
            rd_valid_s1 <= accept_rd;
            rd_valid_s2 <= rd_valid_s1;
            rd_data_s2  <= rd_valid_s1 ? rd_word : 16'h0000;
        end
    end

    assign bus.data_out   = rd_data_s2;
    assign bus.data_valid = rd_valid_s2;
    assign bus.stall      = stall_now;
    assign bus.busy       = busy_flags;
    assign bus.err        = err_now;
endmodule

// File: tb/tb_banked_mem.sv
// Scoreboard bench for banked_mem: randomized requests against a model that
// tracks bank free times and word contents, plus a short BUSY_CYCLES=2 check.
module tb_banked_mem;
    localparam int BC = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    banked_mem_if bus ();
    banked_mem_if bus2 ();

    banked_mem #(.BUSY_CYCLES(BC)) dut  (.clk(clk), .rst(rst),  .bus(bus.slave));
    banked_mem #(.BUSY_CYCLES(2))  dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t     sbq[$];
    logic [15:0] mdl [0:31];
    int          free_at [4];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One cycle on the main DUT: drive, check combinational flags, update model.
    task automatic do_cycle(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic rs,
                            output bit acc, output bit stl);
        logic       e;
        logic [3:0] eb;
        int         b;
        bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d; rst = rs;
        @(negedge clk);
        e = (r & w) | ((r | w) & a[0]);
        b = int'(a[2:1]);
        for (int k = 0; k < 4; k++) eb[k] = (cyc < free_at[k]);
        stl = (r | w) & ~e & eb[b];
        chk("err",   32'(bus.err),   32'(e));
        chk("stall", 32'(bus.stall), 32'(stl));
        chk("busy",  32'(bus.busy),  32'(eb));
        acc = (r ^ w) & ~e & ~stl & ~rs;
        if (acc) begin
            free_at[b] = cyc + BC;
            if (w) mdl[a[5:1]] = d;
            else   sbq.push_back('{cyc + 2, mdl[a[5:1]]});
        end
        if (rs) begin
            for (int k = 0; k < 4; k++) free_at[k] = 0;
            while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
        end
        advance();
    endtask

    task automatic issue(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, output int tries);
        bit acc, stl;
        tries = 0;
        do begin
            do_cycle(r, w, a, d, 1'b0, acc, stl);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc, stl;
        repeat (n) do_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc, stl);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.data_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.data_valid), 32'd0);
                end else begin
                    rd_exp_t e;
                    e = sbq.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rd_data", 32'(bus.data_out), 32'(e.data));
                end
            end else begin
                chk("idle_data", 32'(bus.data_out), 32'd0);
                if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    chk("rd_missing", 32'(bus.data_valid), 32'd1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  tries;
        bit  acc, stl;
        bit  held;
        logic        r_q, w_q, rs_q;
        logic [15:0] a_q, d_q;
        int  op;

        bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.data_in = 0;
        bus2.rd = 0; bus2.wr = 0; bus2.addr = 0; bus2.data_in = 0;
        rst = 1'b1; rst2 = 1'b1;
        for (int k = 0; k < 4; k++) free_at[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        @(negedge clk);
        chk("reset_busy",  32'(bus.busy),       32'd0);
        chk("reset_valid", 32'(bus.data_valid), 32'd0);
        chk("reset_data",  32'(bus.data_out),   32'd0);
        chk("reset_err",   32'(bus.err),        32'd0);
        advance();
        rst2 = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 32; i++) issue(1'b0, 1'b1, 16'(i << 1), 16'($urandom), tries);
        idle(4);

        // Write then read same word four cycles later: no stall, data two later.
        issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, tries);
        idle(3);
        issue(1'b1, 1'b0, 16'h0010, 16'h0, tries);
        chk("wr_rd_no_stall", 32'(tries), 32'd1);
        idle(4);

        // Back-to-back reads on different banks.
        issue(1'b0, 1'b1, 16'h0000, 16'h1111, tries);
        issue(1'b0, 1'b1, 16'h0002, 16'h2222, tries);
        idle(4);
        issue(1'b1, 1'b0, 16'h0000, 16'h0, tries);
        issue(1'b1, 1'b0, 16'h0002, 16'h0, tries);
        chk("b2b_no_stall", 32'(tries), 32'd1);
        idle(4);

        // Same-bank read held behind a write: accepted on the fourth attempt.
        issue(1'b0, 1'b1, 16'h0000, 16'h3333, tries);
        issue(1'b1, 1'b0, 16'h0008, 16'h0, tries);
        chk("held_rd_tries", 32'(tries), 32'd4);
        idle(4);

        // Illegal requests alter nothing.
        do_cycle(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b0, acc, stl);
        do_cycle(1'b0, 1'b1, 16'h0003, 16'hDEAD, 1'b0, acc, stl);
        issue(1'b1, 1'b0, 16'h0020, 16'h0, tries);
        issue(1'b1, 1'b0, 16'h0002, 16'h0, tries);
        idle(4);

        // Reset drops an in-flight read and frees the bank.
        issue(1'b1, 1'b0, 16'h0004, 16'h0, tries);
        do_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc, stl);
        issue(1'b1, 1'b0, 16'h0004, 16'h0, tries);
        chk("post_reset_accept", 32'(tries), 32'd1);
        idle(4);

        held = 1'b0;
        r_q = 0; w_q = 0; a_q = 0; d_q = 0; rs_q = 0;
        repeat (1500) begin
            if (!held) begin
                op   = $urandom_range(0, 9);
                a_q  = 16'($urandom_range(0, 31) << 1);
                d_q  = 16'($urandom);
                r_q  = (op <= 3) || (op == 8) || (op == 9);
                w_q  = (op >= 4 && op <= 6) || (op == 8);
                if (op == 9) a_q[0] = 1'b1;
                if (op == 7) begin r_q = 0; w_q = 0; end
                rs_q = ($urandom_range(0, 49) == 0);
            end
            do_cycle(r_q, w_q, a_q, d_q, rs_q, acc, stl);
            held = stl && !rs_q;
        end
        idle(6);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        // BUSY_CYCLES=2 instance: same-bank write then read.
        bus2.wr = 1; bus2.rd = 0; bus2.addr = 16'h0000; bus2.data_in = 16'h1234;
        @(negedge clk);
        chk("bc2_c0_stall", 32'(bus2.stall), 32'd0);
        chk("bc2_c0_busy",  32'(bus2.busy),  32'd0);
        advance();
        bus2.wr = 0; bus2.rd = 1;
        @(negedge clk);
        chk("bc2_c1_stall", 32'(bus2.stall), 32'd1);
        chk("bc2_c1_busy",  32'(bus2.busy),  32'd1);
        advance();
        @(negedge clk);
        chk("bc2_c2_stall", 32'(bus2.stall), 32'd0);
        chk("bc2_c2_busy",  32'(bus2.busy),  32'd0);
        advance();
        bus2.rd = 0;
        @(negedge clk);
        chk("bc2_c3_busy",  32'(bus2.busy),       32'd1);
        chk("bc2_c3_valid", 32'(bus2.data_valid), 32'd0);
        advance();
        @(negedge clk);
        chk("bc2_c4_valid", 32'(bus2.data_valid), 32'd1);
        chk("bc2_c4_data",  32'(bus2.data_out),   32'h1234);
        chk("bc2_c4_busy",  32'(bus2.busy),       32'd0);
        advance();
        @(negedge clk);
        chk("bc2_c5_valid", 32'(bus2.data_valid), 32'd0);
        chk("bc2_c5_data",  32'(bus2.data_out),   32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
